tenhalf_deal_arbiter: RTL and testbench
=======================================

# tenhalf_deal_arbiter

Shares the game's single card source, the LUT with its pip/number interface, between the player and dealer sides of the ten-and-a-half game. It arbitrates the two requesters round-robin and sequences the LUT pulse and its sampling window. It optionally rejects ranks already dealt four times, and returns each card with its half-point value. It sits between the game FSM and the LUT instance; the game FSM no longer drives pip directly.

## Interface
Parameters:
- LUT_LAT, 2: cycles from lut_pip high to lut_number valid (1..15)
- MAX_REDRAW, 8: consecutive rejected draws tolerated before err is raised

Ports:
- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- req  in  2  card request level; bit0 player, bit1 dealer
- deck_clr  in  1  synchronous new-game clear
- lut_number  in  4  raw rank from LUT
- lut_pip  out  1  one-cycle draw strobe to LUT
- gnt  out  2  one-hot, one-cycle grant pulse
- card_vld  out  1  one-cycle card delivery strobe
- card_id  out  1  destination of delivered card; 0 player, 1 dealer
- card_rank  out  4  rank 1..13
- card_val2  out  5  value x2: ranks 1..10 give 2*rank, ranks 11..13 give 1
- busy  out  1  high in every state except IDLE
- err  out  1  sticky: deck exhausted or redraw limit hit

## Operation
- States: IDLE, ISSUE, WAIT, CHECK, DELIVER.
- IDLE
  - With any req bit high and err=0, latch the winner and go to ISSUE.
  - Tie-break: grant the side not served last.
  - The last-served pointer resets to dealer, so the player wins the first tie.
- ISSUE
  - lut_pip=1 for one cycle.
  - gnt[winner]=1 on the first issue of a transaction only; never on redraws.
  - Load wait counter with LUT_LAT; go to WAIT.
- WAIT
  - Decrement the counter.
  - On the cycle the counter reaches 0, register lut_number and go to CHECK.
- CHECK
  - Reject if the rank is 0 or greater than 13, or (macro on) the rank count is already 4.
  - On reject: increment the redraw counter and return to ISSUE.
  - If the redraw counter reaches MAX_REDRAW, set err, go to IDLE and emit no card.
  - On accept: go to DELIVER.
- DELIVER
  - card_vld=1 for one cycle, with card_id, card_rank and card_val2 held stable that cycle.
  - Increment the rank count and dealt count.
  - Clear the redraw counter, update the last-served pointer, go to IDLE.
- Data outputs hold their last values until the next DELIVER.
- A requester holds req until it sees card_vld with a matching card_id, then deasserts req on the next cycle.
  - If req drops mid-transaction, the transaction still completes and delivers.
- deck_clr, highest priority, any state:
  - abort to IDLE without card_vld;
  - clear rank counts, dealt count, redraw counter and err;
  - reset the pointer to dealer.
- Simultaneous deck_clr and request: the clear wins; the request is evaluated next cycle.
- While err=1 no grants are issued; req is ignored until deck_clr.

## Timing
- Reset values: gnt=0, card_vld=0, card_id=0, card_rank=0, card_val2=0, lut_pip=0, busy=0, err=0; state IDLE.
- All outputs are registered.
- Latency without redraw: req sampled at edge N, then:
  - gnt and lut_pip high in cycle N+1;
  - card_vld high in cycle N+LUT_LAT+3.
  - For LUT_LAT=2: 5 cycles.
- Each redraw adds LUT_LAT+2 cycles.
- Minimum spacing between consecutive card_vld pulses: LUT_LAT+4 cycles.
- Arithmetic widths:
  - card_val2 maximum is 20, fits 5 bits;
  - rank counters are 3-bit, saturating at 4;
  - dealt counter is 6-bit.

## Configuration
- DEAL_DUP_FILTER_EN defined:
  - per-rank counters and the dealt counter are compiled in;
  - a rank already dealt 4 times is rejected and redrawn;
  - with dealt count at 52, a new request sets err directly from IDLE, with no ISSUE.
- DEAL_DUP_FILTER_EN undefined:
  - no counters;
  - only out-of-range ranks (0, 14, 15) are rejected;
  - err arises solely from MAX_REDRAW.

## Structure
- Shared package tenhalf_pkg contains:
  - the state enum;
  - RANK_MAX=13, SUIT_CNT=4, DECK_SIZE=52;
  - PLAYER_ID=0, DEALER_ID=1;
  - function rank_to_val2.
- Sub-module tenhalf_rank_tracker holds the 13 rank counters and the dealt counter.
  - Inputs: inc, rank, clr.
  - Outputs: rank_full, deck_empty.
  - Instantiated only under DEAL_DUP_FILTER_EN.

## Test plan
- Player req alone, LUT returns 7 with LUT_LAT=2 -> gnt=01 in cycle 1, lut_pip once, card_vld in cycle 5 with card_id=0, rank=7, val2=14.
- Both req high from reset, LUT returns 12 then 3 -> player served first (val2=1), dealer second (rank=3, val2=6); exactly 2 gnt pulses.
- LUT returns 0, 15, then 10 -> two extra lut_pip pulses, a single gnt, card delivered with val2=20 after 5+2*4=13 cycles.
- Macro on, LUT forced to 5 -> four deliveries of rank 5; fifth request redraws 8 times, then err=1, no card_vld, later req ignored.
- deck_clr pulsed during WAIT -> no card_vld, busy=0 next cycle, err=0, counts cleared; a following request is served normally.
- Async rst_n asserted mid-DELIVER -> all outputs 0 immediately; after release, a player request gets gnt on the second cycle.

Source files
------------

// File: rtl/tenhalf_pkg.sv
// Shared types, deck constants and card value helper for the ten-and-a-half dealer.
package tenhalf_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_WAIT,
        ST_CHECK,
        ST_DELIVER
    } deal_state_e;

    localparam int RANK_MAX  = 13;
    localparam int SUIT_CNT  = 4;
    localparam int DECK_SIZE = 52;

    localparam logic PLAYER_ID = 1'b0;
    localparam logic DEALER_ID = 1'b1;

    // Values are kept doubled so the face cards' half point stays an integer.
    function automatic logic [4:0] rank_to_val2(input logic [3:0] rank);
        if (rank >= 4'd11)
            return 5'd1;
        else
            return {rank, 1'b0};
    endfunction

endpackage

// File: rtl/tenhalf_rank_tracker.sv
// Per-rank and total dealt-card counters; only built when DEAL_DUP_FILTER_EN is defined.
`ifdef DEAL_DUP_FILTER_EN
module tenhalf_rank_tracker
    import tenhalf_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       inc,
    input  logic [3:0] rank,
    input  logic       clr,
    output logic       rank_full,
    output logic       deck_empty
);

    // Indexed directly by the 4-bit rank; entries 0, 14 and 15 are never incremented.
    logic [2:0] rank_cnt [16];
    logic [5:0] dealt_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 16; i++)
                rank_cnt[i] <= '0;
            dealt_cnt <= '0;
        end else if (clr) begin
            for (int i = 0; i < 16; i++)
                rank_cnt[i] <= '0;
            dealt_cnt <= '0;
        end else if (inc) begin
            if (rank_cnt[rank] < 3'(SUIT_CNT))
                rank_cnt[rank] <= rank_cnt[rank] + 3'd1;
            if (dealt_cnt < 6'(DECK_SIZE))
                dealt_cnt <= dealt_cnt + 6'd1;
        end
    end

    assign rank_full  = (rank_cnt[rank] == 3'(SUIT_CNT));
    assign deck_empty = (dealt_cnt == 6'(DECK_SIZE));

endmodule
`endif

// File: rtl/tenhalf_deal_arbiter.sv
// Round-robin arbiter sharing the card LUT between player and dealer, with redraw on bad ranks.
// Optional duplicate-rank filtering and deck exhaustion check under DEAL_DUP_FILTER_EN.
module tenhalf_deal_arbiter
    import tenhalf_pkg::*;
#(
    parameter int LUT_LAT    = 2,
    parameter int MAX_REDRAW = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] req,
    input  logic       deck_clr,
    input  logic [3:0] lut_number,
    output logic       lut_pip,
    output logic [1:0] gnt,
    output logic       card_vld,
    output logic       card_id,
    output logic [3:0] card_rank,
    output logic [4:0] card_val2,
    output logic       busy,
    output logic       err
);

    deal_state_e state;
    logic        winner;
    logic        last_id;
    logic        next_winner;
    logic [3:0]  lat_cnt;
    logic [3:0]  rank_q;
    logic [7:0]  redraw_cnt;
    logic        rank_ok;
    logic        rank_full;
    logic        deck_empty;

`ifdef DEAL_DUP_FILTER_EN
    tenhalf_rank_tracker u_tracker (
        .clk        (clk),
        .rst_n      (rst_n),
        .inc        (state == ST_DELIVER),
        .rank       (rank_q),
        .clr        (deck_clr),
        .rank_full  (rank_full),
        .deck_empty (deck_empty)
    );
`else
    assign rank_full  = 1'b0;
    assign deck_empty = 1'b0;
`endif

    // On a tie the side not served last wins.
    assign next_winner = (req == 2'b11) ? ~last_id : req[1];
    assign rank_ok     = (rank_q != 4'd0) && (rank_q <= 4'(RANK_MAX)) && !rank_full;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ST_IDLE;
            winner     <= PLAYER_ID;
            last_id    <= DEALER_ID;
            lat_cnt    <= '0;
            rank_q     <= '0;
            redraw_cnt <= '0;
            lut_pip    <= 1'b0;
            gnt        <= '0;
            card_vld   <= 1'b0;
            card_id    <= 1'b0;
            card_rank  <= '0;
            card_val2  <= '0;
            busy       <= 1'b0;
            err        <= 1'b0;
        end else if (deck_clr) begin
            state      <= ST_IDLE;
            last_id    <= DEALER_ID;
            redraw_cnt <= '0;
            lut_pip    <= 1'b0;
            gnt        <= '0;
            card_vld   <= 1'b0;
            busy       <= 1'b0;
            err        <= 1'b0;
        end else begin
            lut_pip  <= 1'b0;
            gnt      <= '0;
            card_vld <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (req != 2'b00 && !err) begin
                        if (deck_empty) begin
                            err <= 1'b1;
                        end else begin
                            winner  <= next_winner;
                            gnt     <= next_winner ? 2'b10 : 2'b01;
                            lut_pip <= 1'b1;
                            busy    <= 1'b1;
                            state   <= ST_ISSUE;
                        end
                    end
                end
                ST_ISSUE: begin
                    lat_cnt <= 4'(LUT_LAT);
                    state   <= ST_WAIT;
                end
                ST_WAIT: begin
                    lat_cnt <= lat_cnt - 4'd1;
                    if (lat_cnt == 4'd1) begin
                        rank_q <= lut_number;
                        state  <= ST_CHECK;
                    end
                end
                ST_CHECK: begin
                    if (rank_ok) begin
                        card_vld  <= 1'b1;
                        card_id   <= winner;
                        card_rank <= rank_q;
                        card_val2 <= rank_to_val2(rank_q);
                        state     <= ST_DELIVER;
                    end else if (redraw_cnt == 8'(MAX_REDRAW - 1)) begin
                        redraw_cnt <= redraw_cnt + 8'd1;
                        err        <= 1'b1;
                        busy       <= 1'b0;
                        state      <= ST_IDLE;
                    end else begin
                        // Redraws pulse the LUT again but never re-grant.
                        redraw_cnt <= redraw_cnt + 8'd1;
                        lut_pip    <= 1'b1;
                        state      <= ST_ISSUE;
                    end
                end
                ST_DELIVER: begin
                    redraw_cnt <= '0;
                    last_id    <= winner;
                    busy       <= 1'b0;
                    state      <= ST_IDLE;
                end
                default: begin
                    busy  <= 1'b0;
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_tenhalf_deal_arbiter.sv
// Directed self-checking bench for tenhalf_deal_arbiter with a queued LUT model (LUT_LAT=2).
// The duplicate-filter scenario runs only when DEAL_DUP_FILTER_EN is defined.
module tb_tenhalf_deal_arbiter;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [1:0] req = 2'b00;
    logic       deck_clr = 1'b0;
    logic [3:0] lut_number = 4'd0;
    logic       lut_pip;
    logic [1:0] gnt;
    logic       card_vld;
    logic       card_id;
    logic [3:0] card_rank;
    logic [4:0] card_val2;
    logic       busy;
    logic       err;

    int n_checks = 0;
    int n_fail   = 0;
    int gnt_pulses = 0;
    int pip_pulses = 0;
    int vld_pulses = 0;
    int gnt_snap, pip_snap, vld_snap;

    logic [3:0] lut_q [$];
    logic [3:0] lut_default = 4'd0;

    tenhalf_deal_arbiter #(.LUT_LAT(2), .MAX_REDRAW(8)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req        (req),
        .deck_clr   (deck_clr),
        .lut_number (lut_number),
        .lut_pip    (lut_pip),
        .gnt        (gnt),
        .card_vld   (card_vld),
        .card_id    (card_id),
        .card_rank  (card_rank),
        .card_val2  (card_val2),
        .busy       (busy),
        .err        (err)
    );

    always #5 clk = ~clk;

    // LUT model: each pip pops the next scripted rank, valid well before the sample point.
    always @(posedge clk) begin
        if (lut_pip)
            lut_number <= (lut_q.size() > 0) ? lut_q.pop_front() : lut_default;
    end

    always @(posedge clk) begin
        if (gnt != 2'b00) gnt_pulses++;
        if (lut_pip)      pip_pulses++;
        if (card_vld)     vld_pulses++;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_output(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        n_checks++;
        assert (observed === expected) else begin
            n_fail++;
            $error("[TB] FAIL %s: observed %0d expected %0d", tag, observed, expected);
        end
    endtask

    // One complete uncontested transaction; called one cycle into IDLE, returns with req dropped.
    task automatic apply_request(input logic id, input logic [3:0] exp_rank, input logic [4:0] exp_val2, input string tag);
        req = id ? 2'b10 : 2'b01;
        step();
        check_output({tag, "_gnt"}, 32'(gnt), id ? 32'd2 : 32'd1);
        check_output({tag, "_pip"}, 32'(lut_pip), 32'd1);
        repeat (3) step();
        check_output({tag, "_vld_early"}, 32'(card_vld), 32'd0);
        step();
        check_output({tag, "_vld"}, 32'(card_vld), 32'd1);
        check_output({tag, "_id"}, 32'(card_id), 32'(id));
        check_output({tag, "_rank"}, 32'(card_rank), 32'(exp_rank));
        check_output({tag, "_val2"}, 32'(card_val2), 32'(exp_val2));
        step();
        req = 2'b00;
        check_output({tag, "_vld_done"}, 32'(card_vld), 32'd0);
        check_output({tag, "_busy_done"}, 32'(busy), 32'd0);
    endtask

    // Holds a player request against a LUT that keeps returning rejected ranks.
    task automatic run_redraw_limit(input string tag);
        gnt_snap = gnt_pulses;
        pip_snap = pip_pulses;
        vld_snap = vld_pulses;
        req = 2'b01;
        repeat (40) step();
        check_output({tag, "_err"}, 32'(err), 32'd1);
        check_output({tag, "_busy"}, 32'(busy), 32'd0);
        check_output({tag, "_pips"}, 32'(pip_pulses - pip_snap), 32'd8);
        check_output({tag, "_gnts"}, 32'(gnt_pulses - gnt_snap), 32'd1);
        check_output({tag, "_vlds"}, 32'(vld_pulses - vld_snap), 32'd0);
        repeat (6) step();
        check_output({tag, "_ignored"}, 32'(gnt_pulses - gnt_snap), 32'd1);
        check_output({tag, "_err_sticky"}, 32'(err), 32'd1);
        req = 2'b00;
        deck_clr = 1'b1;
        step();
        deck_clr = 1'b0;
        check_output({tag, "_err_clr"}, 32'(err), 32'd0);
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1;
        check_output("rst_gnt", 32'(gnt), 32'd0);
        check_output("rst_pip", 32'(lut_pip), 32'd0);
        check_output("rst_vld", 32'(card_vld), 32'd0);
        check_output("rst_data", 32'({card_id, card_rank, card_val2}), 32'd0);
        check_output("rst_busy_err", 32'({busy, err}), 32'd0);
        rst_n = 1'b1;
        step();

        // Player alone, rank 7.
        lut_q.push_back(4'd7);
        pip_snap = pip_pulses;
        apply_request(1'b0, 4'd7, 5'd14, "solo");
        check_output("solo_pips", 32'(pip_pulses - pip_snap), 32'd1);

        // Clear and a tied request together: clear wins, then player first, dealer second.
        lut_q.push_back(4'd12);
        lut_q.push_back(4'd3);
        gnt_snap = gnt_pulses;
        deck_clr = 1'b1;
        req = 2'b11;
        step();
        check_output("tie_clr_gnt", 32'(gnt), 32'd0);
        check_output("tie_clr_busy", 32'(busy), 32'd0);
        deck_clr = 1'b0;
        step();
        check_output("tie_gnt_p", 32'(gnt), 32'd1);
        repeat (4) step();
        check_output("tie_vld_p", 32'(card_vld), 32'd1);
        check_output("tie_card_p", 32'({card_id, card_rank, card_val2}), 32'({1'b0, 4'd12, 5'd1}));
        step();
        req = 2'b10;
        step();
        check_output("tie_gnt_d", 32'(gnt), 32'd2);
        repeat (4) step();
        check_output("tie_vld_d", 32'(card_vld), 32'd1);
        check_output("tie_card_d", 32'({card_id, card_rank, card_val2}), 32'({1'b1, 4'd3, 5'd6}));
        step();
        req = 2'b00;
        check_output("tie_gnts", 32'(gnt_pulses - gnt_snap), 32'd2);

        // Two bad ranks then 10: delivered 13 cycles after the sampling edge.
        lut_q.push_back(4'd0);
        lut_q.push_back(4'd15);
        lut_q.push_back(4'd10);
        gnt_snap = gnt_pulses;
        pip_snap = pip_pulses;
        req = 2'b01;
        step();
        check_output("redraw_gnt", 32'(gnt), 32'd1);
        repeat (11) step();
        check_output("redraw_vld_early", 32'(card_vld), 32'd0);
        step();
        check_output("redraw_vld", 32'(card_vld), 32'd1);
        check_output("redraw_card", 32'({card_id, card_rank, card_val2}), 32'({1'b0, 4'd10, 5'd20}));
        step();
        req = 2'b00;
        check_output("redraw_pips", 32'(pip_pulses - pip_snap), 32'd3);
        check_output("redraw_gnts", 32'(gnt_pulses - gnt_snap), 32'd1);

        lut_default = 4'd0;
        run_redraw_limit("limit");

        // Clear while waiting on the LUT, then a normal delivery.
        lut_q.push_back(4'd4);
        lut_q.push_back(4'd9);
        vld_snap = vld_pulses;
        req = 2'b01;
        step();
        step();
        deck_clr = 1'b1;
        step();
        deck_clr = 1'b0;
        check_output("clr_busy", 32'(busy), 32'd0);
        check_output("clr_err", 32'(err), 32'd0);
        check_output("clr_vld", 32'(card_vld), 32'd0);
        step();
        check_output("clr_regnt", 32'(gnt), 32'd1);
        repeat (4) step();
        check_output("clr_card", 32'({card_vld, card_id, card_rank, card_val2}), 32'({1'b1, 1'b0, 4'd9, 5'd18}));
        step();
        req = 2'b00;
        check_output("clr_vlds", 32'(vld_pulses - vld_snap), 32'd1);

`ifdef DEAL_DUP_FILTER_EN
        lut_default = 4'd5;
        for (int i = 0; i < 4; i++)
            apply_request(1'b0, 4'd5, 5'd10, "dup");
        run_redraw_limit("dup_full");
`endif

        // Async reset in the middle of a delivery.
        lut_q.push_back(4'd6);
        lut_q.push_back(4'd6);
        req = 2'b01;
        repeat (5) step();
        check_output("arst_pre_vld", 32'(card_vld), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        check_output("arst_vld", 32'(card_vld), 32'd0);
        check_output("arst_data", 32'({card_id, card_rank, card_val2}), 32'd0);
        check_output("arst_ctrl", 32'({gnt, lut_pip, busy, err}), 32'd0);
        #2 rst_n = 1'b1;
        step();
        check_output("arst_regnt", 32'(gnt), 32'd1);
        repeat (4) step();
        check_output("arst_card", 32'({card_vld, card_id, card_rank, card_val2}), 32'({1'b1, 1'b0, 4'd6, 5'd12}));
        step();
        req = 2'b00;
        step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
